alu: RTL and testbench

16-bit two's-complement adder with a five-flag status word, used as the arithmetic stage of the datapath. Each rising clock edge it registers the sum of operands X and Y, along with sign, zero, carry, parity and overflow flags. Its outputs feed the register file and condition-code logic one cycle later.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_adder4.sv | 33 +++
 rtl/alu.sv | 86 ++++++++
 tb/tb_alu.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the registered adder/flag stage: default width and
// bit positions of the packed status word {S, ZR, CY, P, V}.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam int NUM_FLAGS = 5;
  localparam int FLAG_S    = 4;
  localparam int FLAG_ZR   = 3;
  localparam int FLAG_CY   = 2;
  localparam int FLAG_P    = 1;
  localparam int FLAG_V    = 0;

  typedef logic [NUM_FLAGS-1:0] alu_flags_t;

endpackage

// File: rtl/alu_adder4.sv
// 4-bit ripple-carry slice. Also exposes the carry into bit 3 so the top
// level can form signed overflow as carry-into-MSB XOR carry-out.
module alu_adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c_msb
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  always_comb begin
    o_sum = 4'd0;
    for (int i = 0; i < 4; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_carry
      assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
  endgenerate

  assign o_cout  = w_c[4];
  assign o_c_msb = w_c[3];

endmodule

// File: rtl/alu.sv
// Registered two's-complement adder with status flags S, ZR, CY, P, V.
// One result per cycle, one cycle of latency, async active-low clear.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             S,
  output logic             ZR,
  output logic             CY,
  output logic             P,
  output logic             V
);

  localparam int NSLICE = WIDTH / 4;

  logic [NSLICE:0]  w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_c_msb;
  alu_flags_t       w_flags;

  logic [WIDTH-1:0] r_z;
  alu_flags_t       r_flags;

  assign w_carry[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < NSLICE; g++) begin : g_slice
      if (g == NSLICE - 1) begin : g_top
        alu_adder4 u_add (
          .i_a     (X[4*g +: 4]),
          .i_b     (Y[4*g +: 4]),
          .i_cin   (w_carry[g]),
          .o_sum   (w_sum[4*g +: 4]),
          .o_cout  (w_carry[g+1]),
          .o_c_msb (w_c_msb)
        );
      end else begin : g_low
        // Only the top slice's carry-into-MSB matters for overflow.
        logic w_unused_c_msb;
        alu_adder4 u_add (
          .i_a     (X[4*g +: 4]),
          .i_b     (Y[4*g +: 4]),
          .i_cin   (w_carry[g]),
          .o_sum   (w_sum[4*g +: 4]),
          .o_cout  (w_carry[g+1]),
          .o_c_msb (w_unused_c_msb)
        );
      end
    end
  endgenerate

  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_S]  = w_sum[WIDTH-1];
    w_flags[FLAG_ZR] = ~|w_sum;
    w_flags[FLAG_CY] = w_carry[NSLICE];
    w_flags[FLAG_P]  = ~^w_sum;
    w_flags[FLAG_V]  = w_c_msb ^ w_carry[NSLICE];
  end

  // Reset clears flags outright; ZR and P read 0 while held, not derived from Z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z     <= '0;
      r_flags <= '0;
    end else begin
      r_z     <= w_sum;
      r_flags <= w_flags;
    end
  end

  assign Z  = r_z;
  assign S  = r_flags[FLAG_S];
  assign ZR = r_flags[FLAG_ZR];
  assign CY = r_flags[FLAG_CY];
  assign P  = r_flags[FLAG_P];
  assign V  = r_flags[FLAG_V];

endmodule

// File: tb/tb_alu.sv
// Directed-vector and back-to-back random bench for the registered adder.
module tb_alu;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [4:0]   f;  // {S, ZR, CY, P, V}
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] Z;
  logic         S;
  logic         ZR;
  logic         CY;
  logic         P;
  logic         V;

  int n_vec;
  int n_bad;

  logic [W+4:0] exp_q[$];
  vec_t         vecs[10];

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .S     (S),
    .ZR    (ZR),
    .CY    (CY),
    .P     (P),
    .V     (V)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign-based overflow, independent of the slice carries.
  function automatic logic [W+4:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   sum;
    logic [W-1:0] z;
    logic         v;
    sum = {1'b0, x} + {1'b0, y};
    z   = sum[W-1:0];
    v   = (x[W-1] == y[W-1]) && (z[W-1] != x[W-1]);
    return {z, z[W-1], (z == '0), sum[W], ~^z, v};
  endfunction

  task automatic check(input string nm, input logic [W+4:0] exp);
    logic [W+4:0] act;
    act = {Z, S, ZR, CY, P, V};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got Z=%h SZCPV=%b, expected Z=%h SZCPV=%b",
               nm, act[W+4:5], act[4:0], exp[W+4:5], exp[4:0]);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    X = x;
    Y = y;
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{16'h8FFF, 16'h8000, 16'h0FFF, 5'b00111};
    vecs[1] = '{16'h0001, 16'h0002, 16'h0003, 5'b00010};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 5'b01111};
    vecs[3] = '{16'h7FFF, 16'h0001, 16'h8000, 5'b10001};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 5'b01110};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b10100};
    vecs[6] = '{16'h8000, 16'hFFFF, 16'h7FFF, 5'b00101};
    vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 5'b01010};
    vecs[8] = '{16'h1234, 16'h4321, 16'h5555, 5'b00010};
    vecs[9] = '{16'h7FFF, 16'h7FFF, 16'hFFFE, 5'b10001};

    // Reset held across several edges with nonzero operands.
    rst_n = 1'b0;
    drive(16'h1234, 16'h1111);
    repeat (3) @(negedge clk);
    check("reset_hold", '0);

    // Release away from the edge; first edge loads 0x2345 (6 ones, P=1).
    rst_n = 1'b1;
    @(negedge clk);
    check("first_after_reset", {16'h2345, 5'b00010});

    // Directed table, applied back-to-back.
    foreach (vecs[i]) begin
      drive(vecs[i].x, vecs[i].y);
      @(negedge clk);
      check($sformatf("vec%0d_%h+%h", i, vecs[i].x, vecs[i].y), {vecs[i].z, vecs[i].f});
    end

    // Random back-to-back stream with a mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("midstream_reset_async", '0);
        @(negedge clk);
        check("midstream_reset_held", '0);
        rst_n = 1'b1;
      end
      if (i % 7 == 0) begin
        rx = (i % 2 == 0) ? 16'h7FFF : 16'hFFFF;
        ry = W'($urandom_range(0, 3));
      end else begin
        rx = W'($urandom_range(0, 16'hFFFF));
        ry = W'($urandom_range(0, 16'hFFFF));
      end
      drive(rx, ry);
      exp_q.push_back(model(rx, ry));
      @(negedge clk);
      check($sformatf("rand%0d", i), exp_q.pop_front());
    end

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
